// File: rtl/axi_mem_bist.sv
// axi_mem_bist: AXI4 manager that fills a DDR region with an address-derived pattern, reads it back and reports errors.
// Optional feature macro: MEM_BIST_STOP_ON_ERR_EN (end the test after the read burst holding the first error).
module axi_mem_bist #(
  parameter int unsigned ID_WIDTH     = 1,
  parameter logic [26:0] BASE_ADDR    = 27'h0,
  parameter int unsigned REGION_WORDS = 1024,
  parameter int unsigned BURST_LEN    = 8,
  parameter logic [31:0] SEED         = 32'hA5A5_5A5A
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [15:0]         o_err_cnt,
  output logic [26:0]         o_err_addr,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [26:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [3:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic [ID_WIDTH-1:0] o_arid,
  output logic [26:0]         o_araddr,
  output logic [7:0]          o_arlen,
  output logic [3:0]          o_arsize,
  output logic [1:0]          o_arburst,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [ID_WIDTH-1:0] i_rid,
  input  logic [63:0]         i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rlast,
  input  logic                i_rvalid,
  output logic                o_rready
);

  localparam int unsigned NUM_BURSTS  = REGION_WORDS / BURST_LEN;
  localparam logic [26:0] BURST_BYTES = 27'(BURST_LEN * 8);
  localparam logic [7:0]  LEN         = 8'(BURST_LEN - 1);
  localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE} state_t;

  state_t      state, state_nxt;
  logic [26:0] burst_addr, beat_addr;
  logic [7:0]  beat_cnt;
  logic [31:0] burst_cnt;
  logic [15:0] err_cnt;
  logic [26:0] err_addr;
  logic        err_addr_vld;

  logic [31:0] pat_a;
  logic [63:0] pattern;
  logic        start_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        last_burst, rd_mismatch, err_inc, stop_now;
  logic        unused_ids;

  assign unused_ids = ^{i_bid, i_rid};

  assign pat_a   = {5'b0, beat_addr};
  assign pattern = {SEED ^ pat_a, ~pat_a};

  assign start_acc  = ((state == IDLE) || (state == DONE)) && i_start;
  assign aw_hs      = (state == WR_AW) && i_awready;
  assign w_hs       = (state == WR_W) && i_wready;
  assign b_hs       = (state == WR_B) && i_bvalid;
  assign ar_hs      = (state == RD_AR) && i_arready;
  assign r_hs       = (state == RD_R) && i_rvalid;
  assign last_burst = (burst_cnt == LAST_BURST);

  // A beat with both a data mismatch and a bad rresp counts once.
  assign rd_mismatch = (i_rdata != pattern);
  assign err_inc     = (b_hs && (i_bresp != 2'b00)) ||
                       (r_hs && (rd_mismatch || (i_rresp != 2'b00)));

`ifdef MEM_BIST_STOP_ON_ERR_EN
  assign stop_now = (err_cnt != '0) || err_inc;
`else
  assign stop_now = 1'b0;
`endif

  assign o_awid    = '0;
  assign o_arid    = '0;
  assign o_awaddr  = burst_addr;
  assign o_araddr  = burst_addr;
  assign o_awlen   = LEN;
  assign o_arlen   = LEN;
  assign o_awsize  = 4'd3;
  assign o_arsize  = 4'd3;
  assign o_awburst = 2'b01;
  assign o_arburst = 2'b01;
  assign o_wstrb   = '1;
  assign o_wdata   = pattern;
  assign o_wlast   = (beat_cnt == LEN);

  assign o_busy     = (state != IDLE) && (state != DONE);
  assign o_done     = (state == DONE);
  assign o_err_cnt  = err_cnt;
  assign o_error    = (err_cnt != '0);
  assign o_err_addr = err_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    case (state)
      IDLE, DONE: if (i_start) state_nxt = WR_AW;
      WR_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) state_nxt = WR_W;
      end
      WR_W: begin
        o_wvalid = 1'b1;
        if (i_wready && o_wlast) state_nxt = WR_B;
      end
      WR_B: begin
        o_bready = 1'b1;
        if (i_bvalid) state_nxt = last_burst ? RD_AR : WR_AW;
      end
      RD_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) state_nxt = RD_R;
      end
      RD_R: begin
        o_rready = 1'b1;
        if (i_rvalid && i_rlast) state_nxt = (last_burst || stop_now) ? DONE : RD_AR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_addr   <= BASE_ADDR;
      beat_addr    <= BASE_ADDR;
      beat_cnt     <= '0;
      burst_cnt    <= '0;
      err_cnt      <= '0;
      err_addr     <= '0;
      err_addr_vld <= 1'b0;
    end else begin
      if (start_acc) begin
        burst_addr   <= BASE_ADDR;
        burst_cnt    <= '0;
        err_cnt      <= '0;
        err_addr     <= '0;
        err_addr_vld <= 1'b0;
      end
      if (aw_hs || ar_hs) begin
        beat_addr <= burst_addr;
        beat_cnt  <= '0;
      end
      if (w_hs || r_hs) begin
        beat_addr <= beat_addr + 27'd8;
        beat_cnt  <= beat_cnt + 8'd1;
      end
      // The same counters step the write pass and then the read pass over the region.
      if (b_hs || (r_hs && i_rlast)) begin
        if (last_burst) begin
          burst_cnt  <= '0;
          burst_addr <= BASE_ADDR;
        end else begin
          burst_cnt  <= burst_cnt + 32'd1;
          burst_addr <= burst_addr + BURST_BYTES;
        end
      end
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
      if (r_hs && rd_mismatch && !err_addr_vld) begin
        err_addr     <= beat_addr;
        err_addr_vld <= 1'b1;
      end
    end
  end

endmodule
